// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between NREQ writers.
// One request is granted per cycle, and the winner is registered onto rf_we/rf_wa/rf_wd.
module rf_write_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_wa,
    output logic [DW-1:0]            rf_wd,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     pend_valid
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [IW-1:0] gid_q, gid_d;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic          grant_en;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    // Rotating search starting just after the most recently accepted requester.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(last_q) + k) % NREQ;
            cand_idx = cand[IW-1:0];
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        grant_en  = win_found && !stall && !reset;
        win_addr  = req_addr[int'(win_idx)*AW +: AW];
        win_data  = req_data[int'(win_idx)*DW +: DW];
        req_ready = '0;
        if (grant_en) begin
            req_ready[win_idx] = 1'b1;
        end

        last_d = last_q;
        we_d   = 1'b0;
        wa_d   = wa_q;
        wd_d   = wd_q;
        gid_d  = gid_q;
        if (grant_en) begin
            last_d = win_idx;
            we_d   = |win_addr;   // x0 writes are accepted but never issued
            wa_d   = win_addr;
            wd_d   = win_data;
            gid_d  = win_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IW'(NREQ - 1);
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            gid_q  <= '0;
        end else begin
            last_q <= last_d;
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            gid_q  <= gid_d;
        end
    end

    assign rf_we      = we_q;
    assign rf_wa      = wa_q;
    assign rf_wd      = wd_q;
    assign grant_id   = gid_q;
    assign pend_valid = we_q;

endmodule
